// File: rtl/ifetch_prefetch.sv
// Instruction-fetch initiator: owns the PC, issues single-outstanding word reads and
// buffers returned words with their PCs in a small FIFO for decode.
module ifetch_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, tag_pc;
  logic [31:0]       fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  logic              space, issue, push, pop;

  // The outstanding word (or the one landing this cycle) already owns a slot,
  // so a push can never find the FIFO full.
  always_comb begin
    pop   = (count != '0) & inst_ready & ~redirect;
    occ   = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(state == WAIT);
    space = occ < (CW+1)'(DEPTH);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (!redirect && issue) state_nx = WAIT;
      WAIT: begin
        if (redirect)         state_nx = imem_rvalid ? FETCH : DISCARD;
        else if (imem_rvalid) state_nx = issue ? WAIT : FETCH;
      end
      DISCARD: if (imem_rvalid) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Output / datapath control
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    case (state)
      FETCH: issue = space & ~halt & ~redirect;
      WAIT: begin
        issue = imem_rvalid & space & ~halt & ~redirect;
        push  = imem_rvalid & ~redirect;
      end
      default: ;
    endcase
    if (rst) begin
      issue = 1'b0;
      push  = 1'b0;
    end
  end

  // tag_pc remembers the address of the word currently in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      tag_pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc & ~ADDR_W'(3);
    end else if (issue) begin
      pc     <= pc + ADDR_W'(4);
      tag_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= tag_pc;
    end
  end

  always_comb begin
    imem_req   = issue;
    imem_addr  = rst ? RESET_PC[ADDR_W-1:2] : pc[ADDR_W-1:2];
    inst_valid = ~rst & (count != '0);
    inst       = rst ? 32'd0 : fifo_inst[rd_ptr];
    inst_pc    = rst ? '0    : fifo_pc[rd_ptr];
  end

endmodule
